multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS core's shared-memory, single-ALU datapath. It is a Moore state machine with memory-ready gating. For each instruction it issues the per-cycle datapath strobes: fetch, decode, address/execute, memory and writeback. It recognises the same opcode set as the pipeline decoder: R-format, lw, sw, beq and NOP. It also counts retired instructions and flags unsupported opcodes.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; sampled only in DECODE.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  register-file write data: 1 = MDR.
- reg_dst  output  1  destination register: 1 = rd, 0 = rt.
- reg_write  output  1  register-file write enable.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  output  2  00 = add, 01 = sub, 10 = funct.
- pc_source  output  2  00 = ALU result, 01 = ALUOut.
- state  output  4  current state encoding, for debug.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- retired_count  output  16  retired-instruction counter.
- bad_op  output  1  sticky flag: an unsupported opcode was decoded.

## Operation
State encodings:
- RST = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6, REX = 7, RWB = 8, BEQ = 9.
- Encodings 10–15 are unreachable; if entered, the next state is FETCH.

Outputs per state. Any output not listed is 0.
- RST: all strobes 0.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write assert only when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00. This precomputes the branch target.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
- MEMRD: mem_read = 1, i_or_d = 1.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0.
- MEMWR: mem_write = 1, i_or_d = 1.
- REX: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
- BEQ: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01.

Transitions:
- RST → FETCH.
- FETCH → DECODE when mem_ready = 1; otherwise stay in FETCH.
- DECODE dispatches on opcode:
  - 000000 → REX.
  - 100011 or 101011 → MEMADR.
  - 000100 → BEQ.
  - 100000 (NOP) → FETCH.
  - Any other opcode → FETCH and set bad_op.
- MEMADR → MEMRD for lw, or → MEMWR for sw. The opcode is latched in DECODE, so opcode changes after DECODE are ignored.
- MEMRD → MEMWB when mem_ready = 1; otherwise stay in MEMRD.
- MEMWB → FETCH.
- MEMWR → FETCH when mem_ready = 1; otherwise stay in MEMWR.
- REX → RWB → FETCH.
- BEQ → FETCH.

instr_done is combinational from state and inputs. It asserts in:
- MEMWB;
- RWB;
- BEQ;
- MEMWR when mem_ready = 1;
- DECODE when the opcode is NOP or unsupported.

Counting and flags:
- retired_count increments on each clock edge where instr_done = 1. It wraps from 0xFFFF to 0x0000.
- bad_op stays set until rst.

## Timing
- On rst assertion, regardless of clock or state:
  - state = RST, retired_count = 0, bad_op = 0, latched opcode = 0.
  - All strobes are 0, and instr_done = 0.
- Reset mid-instruction abandons the instruction: no pulse and no count.
- First FETCH is the cycle after rst deasserts.
- Cycles per instruction with mem_ready held at 1:
  - NOP or unsupported: 2.
  - beq: 3.
  - R-format: 4.
  - sw: 4.
  - lw: 5.
- Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds exactly one cycle. During a wait:
  - the state's mem_read or mem_write stays high;
  - pc_write, ir_write and instr_done stay 0.
- mem_ready is ignored in every other state.
- retired_count is updated at the edge that ends the instr_done cycle. It is visible in the next state (FETCH).
- At most one instr_done per instruction. No strobe is ever asserted in RST.

## Test plan
- Reset: assert rst mid-MEMRD → state = 0, all strobes 0, count = 0 immediately. Deassert rst → FETCH on the next edge.
- Instruction mix with mem_ready = 1: sequence R, lw, sw, beq, NOP → state traces 1-2-7-8, 1-2-3-4-5, 1-2-3-6, 1-2-9, 1-2. Total 18 cycles; retired_count = 5.
- Memory stalls: lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD → 10 cycles total. ir_write pulses exactly once; mem_read is high throughout each wait.
- Unsupported opcode 6'b111111 → DECODE to FETCH, bad_op = 1 sticky, instr_done pulses once. A following R-format executes normally.
- Counter wrap: preload to 0xFFFE via a forced state or a long NOP run, then retire 2 instructions → retired_count reads 0x0000.
- Opcode change after DECODE: lw decoded, opcode changed to 101011 during MEMADR → still goes to MEMRD, and mem_write is never asserted.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer driving the per-cycle strobes of the shared-memory, single-ALU MIPS datapath.
// Latency: NOP/unsupported 2 cycles, beq 3, R-format 4, sw 4, lw 5; each memory wait cycle adds one.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR with the request held high; it is ignored in all other states.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic [15:0] retired_count,
  output logic        bad_op
);

  // State encodings are visible on the debug port, so they are fixed values.
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_REX    = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;

  // Opcode field values recognised by the decoder.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  // ALU source / operation / PC source codes.
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;

  logic [3:0]  state_q;
  logic [3:0]  state_d;
  logic [5:0]  op_q;
  logic [15:0] retired_q;
  logic        bad_q;
  logic        op_known;
  logic        op_is_nop;

  // Classify the live opcode; only meaningful while in DECODE.
  always_comb begin
    op_known  = 1'b0;
    op_is_nop = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_known = 1'b1;
      OP_NOP: begin
        op_known  = 1'b1;
        op_is_nop = 1'b1;
      end
      default: begin
        op_known  = 1'b0;
        op_is_nop = 1'b0;
      end
    endcase
  end

  // Next-state logic; memory states hold until mem_ready, unused encodings recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_REX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      // Uses the opcode captured in DECODE; IR-field changes after decode are ignored.
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_REX:    state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset parks in RST so every strobe drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the opcode at decode so the memory path is steered by the decoded instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 6'd0;
    end else if (state_q == S_DECODE) begin
      op_q <= opcode;
    end
  end

  // Retired-instruction counter (wraps naturally) and sticky unsupported-opcode flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= 16'd0;
      bad_q     <= 1'b0;
    end else begin
      retired_q <= retired_q + {15'd0, instr_done};
      if ((state_q == S_DECODE) && !op_known) begin
        bad_q <= 1'b1;
      end
    end
  end

  // Per-state datapath strobes; FETCH load enables and retire pulses are gated by mem_ready where memory is involved.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMMSH;
        instr_done = op_is_nop || !op_known;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_OUT;
        instr_done    = 1'b1;
      end
      default: begin
        instr_done = 1'b0;
      end
    endcase
  end

  assign state         = state_q;
  assign retired_count = retired_q;
  assign bad_op        = bad_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        instr_done;
  logic [15:0] retired_count;
  logic        bad_op;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .retired_count(retired_count), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BQ  = 6'b000100;
  localparam logic [5:0] NOP = 6'b100000;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] sb;
    logic        done;
    logic        bad;
    logic [15:0] cnt;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_bad = 1'b0;

  function automatic logic unsupported(input logic [5:0] op);
    return !(op == RT || op == LW || op == SW || op == BQ || op == NOP);
  endfunction

  // Strobe table written directly from the per-state output list.
  function automatic logic [15:0] exp_strobes(input logic [3:0] st, input logic rdy);
    logic pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, op, ps;
    pcw = 0; pcc = 0; iod = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rd = 0; rw = 0; sa = 0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      4'd1: begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      4'd2: begin sb = 2'b11; end
      4'd3: begin sa = 1; sb = 2'b10; end
      4'd4: begin mr = 1; iod = 1; end
      4'd5: begin rw = 1; m2r = 1; end
      4'd6: begin mw = 1; iod = 1; end
      4'd7: begin sa = 1; op = 2'b10; end
      4'd8: begin rw = 1; rd = 1; end
      4'd9: begin sa = 1; op = 2'b01; pcc = 1; ps = 2'b01; end
      default: ;
    endcase
    return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  function automatic logic [15:0] dut_strobes();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Monitor: every cycle out of reset the DUT presents a strobe set; pop and compare.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      rec_t e;
      rec_t a;
      e = exp_q.pop_front();
      a = {state, dut_strobes(), instr_done, bad_op, retired_count};
      checks++;
      if (a === e) passed++;
      else $display("FAIL cycle_trace t=%0t actual st=%0d sb=%h done=%b bad=%b cnt=%h required st=%0d sb=%h done=%b bad=%b cnt=%h",
                    $time, a.st, a.sb, a.done, a.bad, a.cnt, e.st, e.sb, e.done, e.bad, e.cnt);
    end
  end

  // Drive one cycle's inputs and queue what the controller must show in that cycle.
  task automatic push_cyc(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    rec_t r;
    logic d;
    opcode    = op;
    mem_ready = rdy;
    d = (st == 4'd5) || (st == 4'd8) || (st == 4'd9) || (st == 4'd6 && rdy) ||
        (st == 4'd2 && (op == NOP || unsupported(op)));
    r.st = st; r.sb = exp_strobes(st, rdy); r.done = d; r.bad = m_bad; r.cnt = m_cnt;
    exp_q.push_back(r);
    if (d) m_cnt = m_cnt + 16'd1;
    if (st == 4'd2 && unsupported(op)) m_bad = 1'b1;
  endtask

  task automatic cyc(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    push_cyc(st, op, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_cnt = 16'd0;
    m_bad = 1'b0;
    #1;
    checks++;
    if (state == 4'd0 && dut_strobes() == 16'd0 && instr_done == 1'b0 &&
        retired_count == 16'd0 && bad_op == 1'b0) passed++;
    else $display("FAIL reset_immediate actual st=%0d sb=%h done=%b cnt=%h bad=%b required all zero",
                  state, dut_strobes(), instr_done, retired_count, bad_op);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'd0, rop(), rbit());
  endtask

  // One instruction as a cycle trace: fetch waits, fetch, decode, then the class-specific tail.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst, input bit preload);
    if (preload) begin
      force dut.retired_q = 16'hFFFE;
      m_cnt = 16'hFFFE;
      cyc(4'd1, rop(), 1'b0);
      release dut.retired_q;
    end
    for (int i = 0; i < fst; i++) cyc(4'd1, rop(), 1'b0);
    cyc(4'd1, rop(), 1'b1);
    cyc(4'd2, op, rbit());
    case (op)
      RT: begin cyc(4'd7, rop(), rbit()); cyc(4'd8, rop(), rbit()); end
      LW: begin
        cyc(4'd3, SW, rbit());
        for (int i = 0; i < mst; i++) cyc(4'd4, rop(), 1'b0);
        cyc(4'd4, rop(), 1'b1);
        cyc(4'd5, rop(), rbit());
      end
      SW: begin
        cyc(4'd3, LW, rbit());
        for (int i = 0; i < mst; i++) cyc(4'd6, rop(), 1'b0);
        cyc(4'd6, rop(), 1'b1);
      end
      BQ: cyc(4'd9, rop(), rbit());
      default: ;
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] pick;
    #2;
    do_reset();

    // Mix with memory always ready.
    run_instr(RT, 0, 0, 0);
    run_instr(LW, 0, 0, 0);
    run_instr(SW, 0, 0, 0);
    run_instr(BQ, 0, 0, 0);
    run_instr(NOP, 0, 0, 0);

    // lw with fetch and read waits.
    run_instr(LW, 3, 2, 0);
    run_instr(SW, 1, 3, 0);

    // Unsupported opcode, then a normal R-format.
    run_instr(6'b111111, 0, 0, 0);
    run_instr(RT, 0, 0, 0);

    // Counter wrap: preload, then retire two.
    run_instr(NOP, 0, 0, 1);
    run_instr(BQ, 0, 0, 0);
    run_instr(NOP, 0, 0, 0);

    // Reset in the middle of a lw read wait.
    cyc(4'd1, rop(), 1'b1);
    cyc(4'd2, LW, rbit());
    cyc(4'd3, rop(), rbit());
    push_cyc(4'd4, rop(), 1'b0);
    @(negedge clk);
    #1;
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0: pick = RT;
        1: pick = LW;
        2: pick = SW;
        3: pick = BQ;
        4: pick = NOP;
        default: pick = rop();
      endcase
      run_instr(pick, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end
    cyc(4'd1, rop(), 1'b0);

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL queue_drain actual=%0d pending required=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
